// File: rtl/logic_axi4_stream_packet_arbiter_if.sv
// Shared target enumeration and the AXI4-Stream bundle used on both sides of the arbiter.
// The rx modport is the arbiter's receiving view; the tx modport is its sending view.
package logic_pkg;
    typedef enum logic [1:0] {
        TARGET_GENERIC,
        TARGET_XILINX,
        TARGET_INTEL
    } target_t;
endpackage

interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_BYTES*8-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
    modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
endinterface

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Round-robin AXI4-Stream packet arbiter: locks tx to one requester from grant until its tlast beat.
//   state  | meaning
//   IDLE   | no owner; tx idle, all rx stalled; pick next requester after last_grant
//   LOCKED | owner_q drives tx combinationally until its final beat is accepted
module logic_axi4_stream_packet_arbiter #(
    parameter logic_pkg::target_t TARGET = logic_pkg::TARGET_GENERIC,
    parameter int INPUTS      = 2,
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1
) (
    input  logic              aclk,
    input  logic              areset,
    logic_axi4_stream_if.rx   rx [INPUTS],
    logic_axi4_stream_if.tx   tx,
    output logic [INPUTS-1:0] grant
);
    localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int DW    = TDATA_BYTES * 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [INPUTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;

    logic [INPUTS-1:0]      req;
    logic [INPUTS-1:0]      rx_last;
    logic [DW-1:0]          rx_data [INPUTS];
    logic [TDATA_BYTES-1:0] rx_keep [INPUTS];
    logic [TDATA_BYTES-1:0] rx_strb [INPUTS];
    logic [TID_WIDTH-1:0]   rx_id   [INPUTS];
    logic [TDEST_WIDTH-1:0] rx_dest [INPUTS];
    logic [TUSER_WIDTH-1:0] rx_user [INPUTS];

    logic             locked;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    int               scan_idx;

    assign locked = (state_q == LOCKED);

    // Interface arrays only take constant indices, so flatten them for the owner mux.
    for (genvar i = 0; i < INPUTS; i++) begin : g_rx
        assign req[i]     = rx[i].tvalid;
        assign rx_last[i] = rx[i].tlast;
        assign rx_data[i] = rx[i].tdata;
        assign rx_keep[i] = rx[i].tkeep;
        assign rx_strb[i] = rx[i].tstrb;
        assign rx_id[i]   = rx[i].tid;
        assign rx_dest[i] = rx[i].tdest;
        assign rx_user[i] = rx[i].tuser;
        assign rx[i].tready = locked && (owner_q == IDX_W'(i)) && tx.tready;
    end

    // All targets share the generic mux; no vendor primitives are needed.
    if (TARGET != logic_pkg::TARGET_GENERIC) begin : g_target_specific
    end

    assign tx.tvalid = locked && req[owner_q];
    assign tx.tdata  = rx_data[owner_q];
    assign tx.tkeep  = (USE_TKEEP != 0) ? rx_keep[owner_q] : '1;
    assign tx.tstrb  = (USE_TSTRB != 0) ? rx_strb[owner_q] : '1;
    assign tx.tlast  = (USE_TLAST != 0) ? rx_last[owner_q] : 1'b1;
    assign tx.tid    = rx_id[owner_q];
    assign tx.tdest  = rx_dest[owner_q];
    assign tx.tuser  = rx_user[owner_q];

    assign grant = grant_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        last_d     = last_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;

        for (int k = 1; k <= INPUTS; k++) begin
            scan_idx = (int'(last_q) + k) % INPUTS;
            if (!pick_found && req[IDX_W'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(scan_idx);
            end
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = LOCKED;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            LOCKED: begin
                if (tx.tvalid && tx.tready && ((USE_TLAST == 0) || rx_last[owner_q])) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(INPUTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Scoreboard bench: a 3-input packet arbiter and a 2-input per-beat (no tlast) arbiter.
// Expected beats are queued in hand-derived grant order; monitors pop on each tx handshake.
module tb_logic_axi4_stream_packet_arbiter;
    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic_axi4_stream_if rx_a [3] ();
    logic_axi4_stream_if tx_a ();
    logic [2:0]          grant_a;
    logic_axi4_stream_if rx_b [2] ();
    logic_axi4_stream_if tx_b ();
    logic [1:0]          grant_b;

    logic       rv [3];
    logic [7:0] rd [3];
    logic       rl [3];
    logic       rr [3];
    logic       ttr;
    logic       bv;
    logic [7:0] bd [2];

    for (genvar i = 0; i < 3; i++) begin : g_a
        assign rx_a[i].tvalid = rv[i];
        assign rx_a[i].tdata  = rd[i];
        assign rx_a[i].tlast  = rl[i];
        assign rx_a[i].tkeep  = '1;
        assign rx_a[i].tstrb  = '1;
        assign rx_a[i].tid    = '0;
        assign rx_a[i].tdest  = '0;
        assign rx_a[i].tuser  = '0;
        assign rr[i]          = rx_a[i].tready;
    end
    assign tx_a.tready = ttr;

    for (genvar i = 0; i < 2; i++) begin : g_b
        assign rx_b[i].tvalid = bv;
        assign rx_b[i].tdata  = bd[i];
        assign rx_b[i].tlast  = 1'b0;
        assign rx_b[i].tkeep  = '1;
        assign rx_b[i].tstrb  = '1;
        assign rx_b[i].tid    = '0;
        assign rx_b[i].tdest  = '0;
        assign rx_b[i].tuser  = '0;
    end
    assign tx_b.tready = 1'b1;

    logic_axi4_stream_packet_arbiter #(.INPUTS(3)) dut_a (
        .aclk  (aclk),
        .areset(areset),
        .rx    (rx_a),
        .tx    (tx_a),
        .grant (grant_a)
    );

    logic_axi4_stream_packet_arbiter #(.INPUTS(2), .USE_TLAST(0)) dut_b (
        .aclk  (aclk),
        .areset(areset),
        .rx    (rx_b),
        .tx    (tx_b),
        .grant (grant_b)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [2:0] grant;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mk(input int p, input int k, input int b);
        logic [7:0] r;
        r = {p[1:0], k[1:0], b[3:0]};
        return r;
    endfunction

    task automatic exp_pkt(input int p, input int n, input int k);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            e.data  = mk(p, k, b);
            e.last  = (b == n - 1);
            e.grant = 3'(1 << p);
            qa.push_back(e);
        end
    endtask

    task automatic beat(input int p, input logic [7:0] d, input logic last);
        logic acc;
        int   n;
        rv[p] = 1'b1;
        rd[p] = d;
        rl[p] = last;
        acc   = 1'b0;
        n     = 0;
        while (!acc && n < 200) begin
            @(negedge aclk);
            acc = rr[p];
            @(posedge aclk);
            #1;
            n++;
        end
        rv[p] = 1'b0;
        check($sformatf("handshake_rx%0d", p), acc, 1);
    endtask

    task automatic send_pkt(input int p, input int n, input int k);
        for (int b = 0; b < n; b++) beat(p, mk(p, k, b), b == n - 1);
    endtask

    // Monitor for the packet arbiter: order/content plus the mandatory idle gap after tlast.
    initial begin
        exp_t e;
        logic prev_end;
        prev_end = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_end = 1'b0;
            end else begin
                if (prev_end) begin
                    check("gap_a_tvalid", tx_a.tvalid, 0);
                    check("gap_a_grant", grant_a, 0);
                end
                prev_end = 1'b0;
                if (tx_a.tvalid && tx_a.tready) begin
                    if (qa.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat_a: got data %0h expected no beat", tx_a.tdata);
                    end else begin
                        e = qa.pop_front();
                        check("a_data", tx_a.tdata, e.data);
                        check("a_last", tx_a.tlast, e.last);
                        check("a_grant", grant_a, e.grant);
                    end
                    prev_end = tx_a.tlast;
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic prev_end;
        prev_end = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_end = 1'b0;
            end else begin
                if (prev_end) check("gap_b_tvalid", tx_b.tvalid, 0);
                prev_end = 1'b0;
                if (tx_b.tvalid && tx_b.tready) begin
                    if (qb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat_b: got data %0h expected no beat", tx_b.tdata);
                    end else begin
                        e = qb.pop_front();
                        check("b_data", tx_b.tdata, e.data);
                        check("b_last", tx_b.tlast, 1);
                        check("b_grant", grant_b, e.grant);
                    end
                    prev_end = 1'b1;
                end
            end
        end
    end

    // Per-beat round-robin: both inputs always requesting, six beats alternating from rx0.
    initial begin
        exp_t e;
        bv    = 1'b0;
        bd[0] = 8'hA0;
        bd[1] = 8'hB1;
        for (int j = 0; j < 6; j++) begin
            e.data  = (j % 2 == 0) ? 8'hA0 : 8'hB1;
            e.last  = 1'b1;
            e.grant = (j % 2 == 0) ? 3'b001 : 3'b010;
            qb.push_back(e);
        end
        wait (!areset);
        @(posedge aclk);
        #1;
        bv = 1'b1;
        for (int n = 0; n < 100 && qb.size() != 0; n++) begin
            @(posedge aclk);
            #1;
        end
        bv = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   done;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0;
            rd[i] = '0;
            rl[i] = 1'b0;
        end
        ttr = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_grant", grant_a, 0);
        check("rst_tvalid", tx_a.tvalid, 0);
        for (int i = 0; i < 3; i++) check($sformatf("rst_tready%0d", i), rr[i], 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_tvalid", tx_a.tvalid, 0);
        @(posedge aclk);
        #1;

        // Three simultaneous 4-beat packets: served 0, 1, 2 with one-cycle arbitration latency.
        exp_pkt(0, 4, 0);
        exp_pkt(1, 4, 0);
        exp_pkt(2, 4, 0);
        fork
            send_pkt(0, 4, 0);
            send_pkt(1, 4, 0);
            send_pkt(2, 4, 0);
            begin
                @(negedge aclk);
                check("lat_idle_tvalid", tx_a.tvalid, 0);
                @(negedge aclk);
                check("lat_first_tvalid", tx_a.tvalid, 1);
            end
        join
        repeat (2) @(posedge aclk);
        #1;

        // rx0 back-to-back, rx1 joins mid-packet and takes the next slot.
        exp_pkt(0, 3, 1);
        exp_pkt(1, 3, 1);
        exp_pkt(0, 3, 2);
        fork
            begin
                send_pkt(0, 3, 1);
                send_pkt(0, 3, 2);
            end
            begin
                repeat (2) @(posedge aclk);
                #1;
                send_pkt(1, 3, 1);
            end
        join
        repeat (2) @(posedge aclk);
        #1;

        // Owner rx1 stalls five cycles mid-packet while rx0 waits.
        exp_pkt(1, 4, 2);
        exp_pkt(0, 2, 3);
        fork
            begin
                beat(1, mk(1, 2, 0), 1'b0);
                beat(1, mk(1, 2, 1), 1'b0);
                for (int c = 0; c < 5; c++) begin
                    @(negedge aclk);
                    check("stall_grant", grant_a, 3'b010);
                    check("stall_tvalid", tx_a.tvalid, 0);
                    check("stall_rx0_tready", rr[0], 0);
                    @(posedge aclk);
                    #1;
                end
                beat(1, mk(1, 2, 2), 1'b0);
                beat(1, mk(1, 2, 3), 1'b1);
            end
            begin
                repeat (2) @(posedge aclk);
                #1;
                send_pkt(0, 2, 3);
            end
        join
        repeat (2) @(posedge aclk);
        #1;

        // 16-beat packet under random tx backpressure.
        exp_pkt(2, 16, 1);
        done = 1'b0;
        fork
            begin
                send_pkt(2, 16, 1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge aclk);
                    #1;
                    ttr = 1'($urandom_range(0, 1));
                end
            end
        join
        ttr = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // Reset on beat 2 of an rx1 packet; afterwards rx0 wins first.
        e.data = mk(1, 0, 0); e.last = 1'b0; e.grant = 3'b010; qa.push_back(e);
        e.data = mk(1, 0, 1); e.last = 1'b0; e.grant = 3'b010; qa.push_back(e);
        beat(1, mk(1, 0, 0), 1'b0);
        beat(1, mk(1, 0, 1), 1'b0);
        rv[1]  = 1'b1;
        rd[1]  = mk(1, 0, 2);
        rl[1]  = 1'b0;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("midrst_grant", grant_a, 0);
        check("midrst_tvalid", tx_a.tvalid, 0);
        check("midrst_rx1_tready", rr[1], 0);
        rv[1] = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_pkt(0, 2, 2);
        exp_pkt(1, 2, 2);
        fork
            send_pkt(0, 2, 2);
            send_pkt(1, 2, 2);
        join
        repeat (3) @(posedge aclk);
        #1;

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_axi4_stream_packet_arbiter.md
LOGIC_AXI4_STREAM_PACKET_ARBITER -- requirements
Module: logic_axi4_stream_packet_arbiter

Interface
REQ-001 SHALL have parameter TARGET, default logic_pkg::TARGET_GENERIC: target device implementation.
REQ-002 SHALL have parameter INPUTS, default 2: number of rx requesters, legal range 1..16.
REQ-003 SHALL have parameters TDATA_BYTES=1, TDEST_WIDTH=1, TUSER_WIDTH=1, TID_WIDTH=1: AXI4-Stream field widths, applied identically to rx and tx.
REQ-004 SHALL have parameters USE_TLAST=1, USE_TKEEP=1, USE_TSTRB=1: field enables, 0 = field ignored or driven constant.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port rx, logic_axi4_stream_if rx modport array [INPUTS]: requester streams.
REQ-008 SHALL have port tx, logic_axi4_stream_if tx modport: arbitrated stream, typically feeding logic_axi4_stream_packet_buffer.
REQ-009 SHALL have port grant, output, INPUTS bits: one-hot owner of tx, all-zero when idle.

Function
REQ-010 SHALL implement FSM states IDLE and LOCKED.
REQ-011 In IDLE, tx.tvalid SHALL be 0 and every rx[i].tready SHALL be 0.
REQ-012 In IDLE with at least one rx[i].tvalid=1, the FSM SHALL register grant to the first requesting index after last_grant, searched cyclically (last_grant+1 ... INPUTS-1, 0 ... last_grant), and enter LOCKED on the next edge.
REQ-013 Arbitration latency SHALL be exactly 1 cycle: first tx.tvalid=1 one cycle after the requester's tvalid is seen in IDLE.
REQ-014 In LOCKED with owner g, tx.tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser SHALL combinationally equal rx[g] fields.
REQ-015 In LOCKED, rx[g].tready SHALL equal tx.tready; rx[i].tready for i!=g SHALL be 0.
REQ-016 Ownership SHALL hold until a beat with rx[g].tvalid & tx.tready & rx[g].tlast; on that edge last_grant<=g, grant<=0, FSM->IDLE.
REQ-017 With USE_TLAST=0, every accepted beat SHALL end ownership, giving per-beat round-robin.
REQ-018 A grant SHALL persist while the owner's tvalid is 0 mid-packet; no timeout, no preemption.
REQ-019 Requests arriving while LOCKED SHALL wait; no request SHALL be starved for more than INPUTS-1 packets.
REQ-020 Packets SHALL never interleave on tx: between a grant and its tlast beat, tx carries only rx[g] beats.
REQ-021 A tx-side gap of at least one IDLE cycle SHALL occur between consecutive packets.
REQ-022 With INPUTS=1, behaviour SHALL be identical, with grant toggling 1/0 per packet.
REQ-023 last_grant SHALL be ceil(log2(INPUTS)) bits, minimum 1; the cyclic search SHALL wrap modulo INPUTS.
REQ-024 Output disabled fields (USE_TKEEP=0 / USE_TSTRB=0) SHALL be driven all-ones; USE_TLAST=0 SHALL drive tx.tlast=1.

Reset
REQ-025 While areset=1 at a rising edge, FSM SHALL go to IDLE, grant<=0, last_grant<=INPUTS-1 so rx[0] has first priority.
REQ-026 During and on the cycle after reset, tx.tvalid=0 and all rx[i].tready=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet immediately; no recovery or tlast insertion.
REQ-028 No output SHALL depend on areset combinationally except through registered state.

Verification
REQ-029 INPUTS=3, tx.tready=1, rx0/rx1/rx2 each present a 4-beat packet at cycle 0 after reset -> grant 001, 010, 100 in order; tx shows 12 beats with one IDLE cycle after each tlast.
REQ-030 INPUTS=2, rx0 sends 3-beat packets back-to-back, rx1 requests once at cycle 2 -> rx1's packet follows rx0's first packet; rx0 resumes afterwards.
REQ-031 Owner rx1 drops tvalid for 5 cycles mid-packet while rx0 requests -> grant stays 10, tx.tvalid=0 for those 5 cycles, rx0.tready=0 throughout.
REQ-032 tx.tready toggling random 50% during a 16-beat packet -> all 16 beats delivered in order, no beat duplicated or lost, grant released only after tlast handshake.
REQ-033 areset=1 asserted on beat 2 of a 4-beat packet -> next cycle grant=0, tx.tvalid=0; after release, rx0 wins first despite prior owner rx1.
REQ-034 USE_TLAST=0, INPUTS=2, both requesting continuously -> tx alternates rx0, rx1 one beat each, separated by one IDLE cycle.
